mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage between EXE and WB. Consumes EXE's registered outputs, performs loads and stores against a data-memory port with a request/acknowledge handshake, and aligns and sign-extends load data. Stalls the upstream pipeline while an access waits, then registers the writeback value, destination and control for WB. Also drives the MEM-stage forwarding taps back to EXE.

## Interface
- `OP_LB` = 6'h20; `OP_LH` = 6'h21; `OP_LW` = 6'h23; `OP_LBU` = 6'h24; `OP_LHU` = 6'h25: ALU_Control load codes.
- `OP_SB` = 6'h28; `OP_SH` = 6'h29; `OP_SW` = 6'h2B: ALU_Control store codes.
- `CLK` in 1: single clock; all state updates on posedge.
- `RESET` in 1: asynchronous, active-low.
- `Instr1_IN`, `Instr1_PC_IN` in 32: debug instruction and PC from EXE.
- `ALU_result1_IN` in 32: ALU result, used as the effective address when accessing memory.
- `WriteRegister1_IN` in 5: destination register.
- `MemWriteData1_IN` in 32: store data.
- `RegWrite1_IN`, `MemRead1_IN`, `MemWrite1_IN` in 1: control from EXE.
- `ALU_Control1_IN` in 6: selects access size and extension.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: `{addr[31:2], 2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_rdata` in 32: read data, valid when `dmem_ack` = 1.
- `dmem_ack` in 1: completion of the current request.
- `Stall_OUT` out 1: freeze IF/ID/EXE this cycle.
- `MemFwdReg_OUT` out 5; `MemFwdData_OUT` out 32: combinational forwarding taps. They equal `WriteRegister1_IN` and `ALU_result1_IN`. The register tap is 0 when `RegWrite1_IN` = 0.
- `Instr1_OUT`, `Instr1_PC_OUT` out 32: registered, to WB.
- `WriteData1_OUT` out 32: registered writeback value.
- `WriteRegister1_OUT` out 5: registered, to WB.
- `RegWrite1_OUT` out 1: registered, to WB.
- `StallCount_OUT` out 32: count of stall cycles, saturating.

## Operation
- **Access present.** `acc = MemRead1_IN | MemWrite1_IN`.
- **Priority.** If both read and write are set, the write wins and `RegWrite` is suppressed.
- **FSM states:** IDLE and WAIT.
  - **IDLE:**
    - `dmem_req = acc` (combinational).
    - If `acc & dmem_ack`: complete this cycle, stay in IDLE.
    - If `acc & !dmem_ack`: go to WAIT.
  - **WAIT:**
    - `dmem_req` is held at 1 with unchanged address, data and enables; the inputs are frozen by the stall.
    - On `dmem_ack`: complete and return to IDLE.
- **Stall.** `Stall_OUT = acc & !dmem_ack`, in either state.
- **On completion, or when there is no access, at posedge:**
  - The outputs take the inputs.
  - `WriteData1_OUT` = extended load data if `MemRead`, else `ALU_result1_IN`.
- **While stalled, at posedge:** bubble into WB.
  - `RegWrite1_OUT` = 0, `WriteRegister1_OUT` = 0, `Instr1_OUT` = 0.
  - `StallCount_OUT` += 1, saturating at 32'hFFFFFFFF.
- **Loads** (lane = `addr[1:0]`):
  - LB/LBU: select byte `rdata[8*lane+7 : 8*lane]`. LB sign-extends, LBU zero-extends.
  - LH/LHU: select half `addr[1] ? rdata[31:16] : rdata[15:0]`, then sign- or zero-extend.
  - Any other code with `MemRead` = 1 is treated as LW.
- **Stores:**
  - SB: `be = 4'b0001 << lane`; `wdata = {4{data[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`; `wdata = {2{data[15:0]}}`.
  - SW, and any other code with `MemWrite` = 1: `be = 4'b1111`.
- **Idle port values.** `dmem_we` = `MemWrite1_IN`. `dmem_be` = 0 when `dmem_req` = 0.

## Timing
- **Zero-wait access** (`ack` in the request cycle): 1-cycle stage latency, `Stall_OUT` stays 0.
- **N-cycle wait:** `Stall_OUT` is high for N cycles, N bubbles reach WB, and the result registers on the ack edge.
- **Unsolicited `dmem_ack`** (no `req`): ignored.
- **Reset value of every output is 0**, including `dmem_req`, `Stall_OUT` and `StallCount_OUT`. FSM resets to IDLE.
- **Reset asserted mid-WAIT:** `dmem_req` drops immediately (asynchronous). The pending access is abandoned, no WB write occurs, and the FSM is in IDLE after release.

## Configuration
- **`MEM_MISALIGN_TRAP_EN` defined:**
  - A misaligned access is LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` != 0.
  - Such an access issues no request and causes no stall.
  - `RegWrite1_OUT` is forced to 0.
  - Output `MisalignErr_OUT` (1 bit, reset 0) pulses high for one cycle.
  - Output `BadAddr_OUT` (32 bits, reset 0) holds the offending address until the next misaligned access.
- **Not defined:**
  - Those ports are absent.
  - Misaligned low address bits are ignored: halfword uses `addr[1]` only, word uses lane 0.

## Test plan
- **LW, zero-wait.** LW at 0x100 with `ack` in the same cycle, `rdata` = 0xDEADBEEF -> `Stall_OUT` = 0; next cycle `WriteData1_OUT` = 0xDEADBEEF, `RegWrite1_OUT` = 1.
- **LB/LBU extension.** LB at 0x103 with `rdata` = 0x80123456 -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- **SH with wait states.** SH at 0x202, data 0x0000ABCD, `ack` after 3 cycles -> `be` = 1100, `wdata` = 0xABCDABCD. `Stall_OUT` is high for 3 cycles; 3 bubbles reach WB; `StallCount_OUT` = 3.
- **Reset in WAIT.** Assert reset during the second WAIT cycle -> `dmem_req` = 0 immediately; all outputs 0; no `RegWrite`.
- **Non-memory op.** ALU op, no memory access, result 0x55 to r7 -> `WriteData1_OUT` = 0x55, `WriteRegister1_OUT` = 7, `dmem_req` never asserted. `MemFwdReg_OUT` = 7 in the input cycle.
- **Misaligned word access.** LW at 0x101.
  - With `MEM_MISALIGN_TRAP_EN`: no `req`, `MisalignErr_OUT` pulses, `BadAddr_OUT` = 0x101.
  - Without it: `req` issued to 0x100.

Source files
------------

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory loads/stores with req/ack handshake, load alignment and
// extension, upstream stall and WB register. Optional misalign trap: MEM_MISALIGN_TRAP_EN.
module mem_access_stage (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr1_IN,
   input  logic [31:0] Instr1_PC_IN,
   input  logic [31:0] ALU_result1_IN,
   input  logic [4:0]  WriteRegister1_IN,
   input  logic [31:0] MemWriteData1_IN,
   input  logic        RegWrite1_IN,
   input  logic        MemRead1_IN,
   input  logic        MemWrite1_IN,
   input  logic [5:0]  ALU_Control1_IN,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        Stall_OUT,
   output logic [4:0]  MemFwdReg_OUT,
   output logic [31:0] MemFwdData_OUT,
   output logic [31:0] Instr1_OUT,
   output logic [31:0] Instr1_PC_OUT,
   output logic [31:0] WriteData1_OUT,
   output logic [4:0]  WriteRegister1_OUT,
   output logic        RegWrite1_OUT,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        MisalignErr_OUT,
   output logic [31:0] BadAddr_OUT,
`endif
   output logic [31:0] StallCount_OUT
);

   localparam logic [5:0] OpLb  = 6'h20;
   localparam logic [5:0] OpLh  = 6'h21;
   localparam logic [5:0] OpLbu = 6'h24;
   localparam logic [5:0] OpLhu = 6'h25;
   localparam logic [5:0] OpSb  = 6'h28;
   localparam logic [5:0] OpSh  = 6'h29;

   typedef enum logic {StIdle, StWait} state_e;
   state_e state_q, state_d;

   logic [31:0] instr_q, instr_d, pc_q, pc_d, wdata_q, wdata_d, cnt_q, cnt_d;
   logic [4:0]  wreg_q, wreg_d;
   logic        regwr_q, regwr_d;
   logic        acc_raw, acc, mis, sz_byte, sz_half, stall;
   logic [1:0]  lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [3:0]  be;
   logic [31:0] st_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        err_q, err_d;
   logic [31:0] bad_q, bad_d;
`endif

   always_comb begin
      acc_raw = MemRead1_IN | MemWrite1_IN;
      lane    = ALU_result1_IN[1:0];
      // Writes take priority, so a read+write decodes with the store size.
      if (MemWrite1_IN) begin
         sz_byte = (ALU_Control1_IN == OpSb);
         sz_half = (ALU_Control1_IN == OpSh);
      end else begin
         sz_byte = (ALU_Control1_IN == OpLb) || (ALU_Control1_IN == OpLbu);
         sz_half = (ALU_Control1_IN == OpLh) || (ALU_Control1_IN == OpLhu);
      end
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = acc_raw & ((sz_half & lane[0]) | (!sz_byte & !sz_half & (lane != 2'b00)));
`endif
      acc = acc_raw & !mis;

      if (sz_byte) begin
         be      = 4'b0001 << lane;
         st_data = {4{MemWriteData1_IN[7:0]}};
      end else if (sz_half) begin
         be      = lane[1] ? 4'b1100 : 4'b0011;
         st_data = {2{MemWriteData1_IN[15:0]}};
      end else begin
         be      = 4'b1111;
         st_data = MemWriteData1_IN;
      end

      ld_byte = dmem_rdata[8*lane +: 8];
      ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ALU_Control1_IN)
         OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         OpLbu:   ld_data = {24'h0, ld_byte};
         OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
         OpLhu:   ld_data = {16'h0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   // Combinational outputs are forced low while reset is held so an abandoned request drops.
   always_comb begin
      stall          = RESET & acc & !dmem_ack;
      dmem_req       = RESET & ((state_q == StWait) | acc);
      dmem_we        = RESET & MemWrite1_IN;
      dmem_addr      = RESET ? {ALU_result1_IN[31:2], 2'b00} : 32'h0;
      dmem_wdata     = RESET ? st_data : 32'h0;
      dmem_be        = dmem_req ? be : 4'b0000;
      Stall_OUT      = stall;
      MemFwdReg_OUT  = (RESET & RegWrite1_IN) ? WriteRegister1_IN : 5'd0;
      MemFwdData_OUT = RESET ? ALU_result1_IN : 32'h0;
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      wdata_d = wdata_q;
      wreg_d  = wreg_q;
      regwr_d = regwr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:  if (acc && !dmem_ack) state_d = StWait;
         StWait:  if (dmem_ack || !acc) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (stall) begin
         instr_d = 32'h0;
         wreg_d  = 5'd0;
         regwr_d = 1'b0;
         if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      end else begin
         instr_d = Instr1_IN;
         pc_d    = Instr1_PC_IN;
         wreg_d  = WriteRegister1_IN;
         wdata_d = (MemRead1_IN && !MemWrite1_IN) ? ld_data : ALU_result1_IN;
         regwr_d = RegWrite1_IN & !(MemRead1_IN & MemWrite1_IN) & !mis;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      err_d = mis;
      bad_d = mis ? ALU_result1_IN : bad_q;
`endif
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= StIdle;
         instr_q <= 32'h0;
         pc_q    <= 32'h0;
         wdata_q <= 32'h0;
         wreg_q  <= 5'd0;
         regwr_q <= 1'b0;
         cnt_q   <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
         bad_q   <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         wdata_q <= wdata_d;
         wreg_q  <= wreg_d;
         regwr_q <= regwr_d;
         cnt_q   <= cnt_d;
`ifdef MEM_MISALIGN_TRAP_EN
         err_q   <= err_d;
         bad_q   <= bad_d;
`endif
      end
   end

   assign Instr1_OUT         = instr_q;
   assign Instr1_PC_OUT      = pc_q;
   assign WriteData1_OUT     = wdata_q;
   assign WriteRegister1_OUT = wreg_q;
   assign RegWrite1_OUT      = regwr_q;
   assign StallCount_OUT     = cnt_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign MisalignErr_OUT    = err_q;
   assign BadAddr_OUT        = bad_q;
`endif

endmodule
